conv_frame_collector: RTL and testbench

Sink for the convolution engine's output stream. It captures valid output pixels into a two-bank ping-pong row buffer, counts columns and rows, and replays each completed row on a valid/ready stream with end-of-row and end-of-frame markers. The downstream file writer or memory writer consumes this stream. The block decouples the free-running convolution output from a back-pressured consumer and flags data loss.

---
 rtl/conv_frame_collector.sv | 142 ++++++++++++++
 tb/tb_conv_frame_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_collector.sv
// Collects the convolution engine's output pixels into a ping-pong row buffer
// and replays each completed row on a valid/ready stream with row/frame markers.
module conv_frame_collector #(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 540,
    parameter int IMAGE_HEIGHT = 360
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic [1:0]           valid,
    output logic [WORD_SIZE-1:0] out_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last_col,
    output logic                 out_last_row,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;

    logic [WORD_SIZE-1:0] mem [2][ROW_SIZE];
    logic [1:0]           bank_full;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [COL_W-1:0]     wr_col;
    logic [COL_W-1:0]     rd_col;
    logic [COL_W-1:0]     rd_col_nxt;
    logic [ROW_W-1:0]     rd_row;
    rd_state_t            state;
    logic                 pix_in;
    logic                 rd_free;
    logic                 wr_accept;
    logic                 wr_fill;

    // A bank whose last pixel is handshaking this cycle counts as drained,
    // so a back-to-back writer never loses the first pixel of the next row.
    assign pix_in     = (valid == 2'b01);
    assign rd_free    = (state == R_STREAM) && out_ready && (rd_col == COL_LAST);
    assign wr_accept  = pix_in && (!bank_full[wr_bank] || (rd_free && (rd_bank == wr_bank)));
    assign wr_fill    = wr_accept && (wr_col == COL_LAST);
    assign rd_col_nxt = rd_col + 1'b1;

    // NOTE: the row RAM has no reset; clearing the bank-full flags is what discards its contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_bank][wr_col] <= inputPixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_col    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            if (pix_in && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (wr_accept) begin
                if (wr_fill) begin
                    wr_col  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (rd_free) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (wr_fill) begin
                bank_full[wr_bank] <= 1'b1;
            end
        end
    end

    // A bank being filled this very cycle is treated as full, saving a cycle of read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= R_IDLE;
            rd_bank      <= 1'b0;
            rd_col       <= '0;
            rd_row       <= '0;
            out_pixel    <= '0;
            out_valid    <= 1'b0;
            out_last_col <= 1'b0;
            out_last_row <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                R_IDLE: begin
                    if (bank_full[rd_bank] || (wr_fill && (wr_bank == rd_bank))) begin
                        state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    out_pixel    <= mem[rd_bank][0];
                    rd_col       <= '0;
                    out_valid    <= 1'b1;
                    out_last_col <= (COL_LAST == '0);
                    out_last_row <= (rd_row == ROW_LAST);
                    state        <= R_STREAM;
                end
                R_STREAM: begin
                    if (out_ready) begin
                        if (rd_col == COL_LAST) begin
                            out_valid    <= 1'b0;
                            out_last_col <= 1'b0;
                            out_last_row <= 1'b0;
                            rd_bank      <= ~rd_bank;
                            if (rd_row == ROW_LAST) begin
                                rd_row     <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                rd_row <= rd_row + 1'b1;
                            end
                            if (bank_full[~rd_bank] || (wr_fill && (wr_bank != rd_bank))) begin
                                state <= R_FETCH;
                            end else begin
                                state <= R_IDLE;
                            end
                        end else begin
                            rd_col       <= rd_col_nxt;
                            out_pixel    <= mem[rd_bank][rd_col_nxt];
                            out_last_col <= (rd_col_nxt == COL_LAST);
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_collector.sv
// Directed bench for conv_frame_collector with 4-pixel rows and 3-row frames;
// a negedge monitor logs every accepted pixel, frame_done pulses and stall stability.
module tb_conv_frame_collector;

    localparam int RS = 4;
    localparam int IH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] inputPixel = '0;
    logic [1:0] valid = 2'b00;
    logic       out_ready = 1'b1;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_last_col;
    logic       out_last_row;
    logic       frame_done;
    logic       overflow;

    conv_frame_collector #(.WORD_SIZE(8), .ROW_SIZE(RS), .IMAGE_HEIGHT(IH)) dut (
        .clk          (clk),
        .rst          (rst),
        .inputPixel   (inputPixel),
        .valid        (valid),
        .out_pixel    (out_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last_col (out_last_col),
        .out_last_row (out_last_row),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor-owned state; the stimulus only reads it relative to a baseline.
    logic [9:0] q [$];
    int         fd_cnt = 0;
    int         fd_bad = 0;
    int         stall_err = 0;
    bit         prev_last_hs = 1'b0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_word = '0;

    int q_base = 0;
    int fd_base = 0;
    int st_base = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall && !(out_valid && ({out_pixel, out_last_col, out_last_row} == prev_word)))
                stall_err++;
            if (frame_done) begin
                fd_cnt++;
                if (!prev_last_hs) fd_bad++;
            end
            if (out_valid && out_ready) q.push_back({out_pixel, out_last_col, out_last_row});
            prev_last_hs = out_valid && out_ready && out_last_col && out_last_row;
            prev_stall   = out_valid && !out_ready;
            prev_word    = {out_pixel, out_last_col, out_last_row};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] v);
        inputPixel = d;
        valid      = v;
        tick(1);
        valid      = 2'b00;
    endtask

    task automatic mark();
        q_base  = q.size();
        fd_base = fd_cnt;
        st_base = stall_err;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        valid = 2'b00;
        tick(2);
        rst = 1'b1;
        tick(1);
        mark();
    endtask

    // Expected stream: pixels base, base+1, ...; last_col every RS-th, last_row on row IH-1.
    task automatic check_stream(input string tag, input int base, input int n, input int row0);
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  px;
        logic        lc;
        logic        lr;
        check({tag, "_count"}, 32'(q.size() - q_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            px  = 8'(base + i);
            lc  = (i % RS) == RS - 1;
            lr  = ((row0 + i / RS) % IH) == IH - 1;
            exp = {22'd0, px, lc, lr};
            got = (q_base + i < q.size()) ? {22'd0, q[q_base + i]} : 32'hFFFF_FFFF;
            check($sformatf("%s_px%0d", tag, i), got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // 1: inputs ignored while held in reset, then a row needs 4 fresh pixels.
        for (int i = 0; i < 6; i++) begin
            inputPixel = 8'(8'h55 + i);
            valid      = 2'b01;
            tick(1);
        end
        check("t1_rst_valid", 32'(out_valid), 32'd0);
        check("t1_rst_overflow", 32'(overflow), 32'd0);
        check("t1_rst_frame_done", 32'(frame_done), 32'd0);
        check("t1_rst_pixel", 32'(out_pixel), 32'd0);
        check("t1_rst_last_col", 32'(out_last_col), 32'd0);
        valid = 2'b00;
        rst   = 1'b1;
        tick(1);
        mark();
        for (int i = 0; i < 3; i++) drive(8'(8'hA0 + i), 2'b01);
        tick(6);
        check("t1_three_px_q", 32'(q.size() - q_base), 32'd0);
        check("t1_three_px_valid", 32'(out_valid), 32'd0);
        drive(8'hA3, 2'b01);
        tick(8);
        check_stream("t1_row", 8'hA0, 4, 0);

        // 2: full frame, consumer always ready.
        do_reset();
        for (int i = 0; i < 12; i++) drive(8'(i), 2'b01);
        tick(12);
        check_stream("t2", 0, 12, 0);
        check("t2_frame_done_cnt", 32'(fd_cnt - fd_base), 32'd1);
        check("t2_frame_done_align", 32'(fd_bad), 32'd0);
        check("t2_overflow", 32'(overflow), 32'd0);

        // 3: priming and invalid codes carry 0xFF and must be ignored.
        mark();
        for (int k = 0; k < 4; k++) begin
            drive(8'hFF, 2'b10);
            drive(8'(8'h10 + k), 2'b01);
            drive(8'hFF, 2'b00);
            drive(8'hFF, 2'b11);
        end
        tick(10);
        check_stream("t3", 8'h10, 4, 0);

        // 4: consumer stalled while 12 pixels arrive; two rows fit, the rest drop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(8'(i), 2'b01);
            if (i == 7) check("t4_overflow_after_8", 32'(overflow), 32'd0);
            if (i == 8) check("t4_overflow_after_9", 32'(overflow), 32'd1);
        end
        tick(8);
        check("t4_stall_valid", 32'(out_valid), 32'd1);
        check("t4_stall_pixel", 32'(out_pixel), 32'd0);
        check("t4_stall_q", 32'(q.size() - q_base), 32'd0);
        check("t4_stall_stable", 32'(stall_err - st_base), 32'd0);
        out_ready = 1'b1;
        tick(16);
        check_stream("t4", 0, 8, 0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // 5: ready toggles every cycle during a row.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            out_ready = (i % 2 == 0);
            drive(8'(8'h20 + i), 2'b01);
        end
        for (int i = 0; i < 16; i++) begin
            out_ready = ~out_ready;
            tick(1);
        end
        out_ready = 1'b1;
        tick(4);
        check_stream("t5", 8'h20, 4, 0);
        check("t5_stall_stable", 32'(stall_err - st_base), 32'd0);

        // 6: asynchronous reset mid-row, then a clean frame.
        do_reset();
        for (int i = 0; i < 6; i++) drive(8'(8'h30 + i), 2'b01);
        @(negedge clk);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_pixel", 32'(out_pixel), 32'd0);
        check("t6_async_last_col", 32'(out_last_col), 32'd0);
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b1;
        tick(1);
        mark();
        for (int i = 0; i < 12; i++) drive(8'(8'h40 + i), 2'b01);
        tick(12);
        check_stream("t6", 8'h40, 12, 0);
        check("t6_frame_done_cnt", 32'(fd_cnt - fd_base), 32'd1);
        check("t6_frame_done_align", 32'(fd_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
